axi_llc_sram_ctrl: RTL and testbench

Request-side controller sitting directly upstream of each LLC data/tag SRAM macro wrapper. Converts a valid/ready request stream into the SRAM's req/gnt handshake, and holds a request until the SRAM grants it (the ECC variant stalls gnt during read-modify-write). It tracks in-flight reads, captures read data and uncorrectable-error flags into a credit-protected response FIFO with valid/ready backpressure, and optionally generates periodic scrub triggers.

---
 rtl/axi_llc_sram_ctrl_pkg.sv | 15 +
 rtl/axi_llc_sram_ctrl_fifo.sv | 68 ++++++
 rtl/axi_llc_sram_ctrl.sv | 129 ++++++++++++
 tb/tb_axi_llc_sram_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_sram_ctrl_pkg.sv
// Shared helpers for the LLC SRAM request controller.
// Read responses are carried as a (rdata, err) struct; its width depends on DataWidth.
package axi_llc_pkg;

    // A counter counting 0..n-1 needs this many bits (never less than one).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Response record layout for a given data width: {rdata, err}.
    function automatic int unsigned rsp_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axi_llc_sram_ctrl_fifo.sv
// Synchronous FIFO with the fifo_v3 interface; holds read responses for the controller.
// Storage resets to zero so the output bus is quiet out of reset.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    dtype                  mem_d [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/axi_llc_sram_ctrl.sv
// Request-side controller in front of an LLC SRAM wrapper: req/gnt conversion, credit-protected
// read response FIFO, optional periodic scrub pulse (enable with AXI_LLC_SRAM_SCRUB_EN).
module axi_llc_sram_ctrl
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumWords      = 1024,
    parameter int unsigned DataWidth     = 128,
    parameter int unsigned ByteWidth     = 8,
    parameter int unsigned NumBanks      = 1,
    parameter int unsigned Latency       = 1,
    parameter int unsigned RspDepth      = 2,
    parameter int unsigned ScrubInterval = 1024,
    localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic                 sram_gnt_i,
    input  logic [DataWidth-1:0] sram_rdata_i,
    input  logic [NumBanks-1:0]  sram_multi_error_i,
    output logic [NumBanks-1:0]  scrub_trigger_o
);
    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned FifoAw   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned RspW     = rsp_width(DataWidth);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } rsp_t;

    logic [CntWidth-1:0] inflight_q, inflight_d, occupancy;
    logic [Latency-1:0]  rd_vld_q, rd_vld_d;
    logic                credits_ok, rd_hs, push, pop;
    logic                fifo_full, fifo_empty;
    logic [FifoAw-1:0]   fifo_usage;
    rsp_t                fifo_in, fifo_out;

    // fifo_v3 usage wraps to zero when full, so full is folded back in here.
    assign occupancy  = fifo_full ? CntWidth'(RspDepth) : CntWidth'(fifo_usage);
    assign credits_ok = ((CntWidth+1)'(inflight_q) + (CntWidth+1)'(occupancy)) < (CntWidth+1)'(RspDepth);

    assign sram_req_o   = req_valid_i & (req_we_i | credits_ok);
    assign req_ready_o  = sram_gnt_i & (req_we_i | credits_ok);
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign rd_hs   = req_valid_i & ~req_we_i & req_ready_o;
    assign push    = rd_vld_q[Latency-1];
    assign pop     = rsp_valid_o & rsp_ready_i;
    assign fifo_in = '{rdata: sram_rdata_i, err: |sram_multi_error_i};

    always_comb begin
        rd_vld_d   = Latency'({rd_vld_q, rd_hs});
        inflight_d = inflight_q;
        if (rd_hs && !push)      inflight_d = inflight_q + 1'b1;
        else if (!rd_hs && push) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q   <= '0;
            inflight_q <= '0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            inflight_q <= inflight_d;
        end
    end

    // Credits guarantee a push never meets a full FIFO.
    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (RspW),
        .DEPTH        (RspDepth),
        .dtype        (rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (fifo_in),
        .push_i  (push),
        .data_o  (fifo_out),
        .pop_i   (pop)
    );

    assign rsp_valid_o = ~fifo_empty;
    assign rsp_rdata_o = fifo_out.rdata;
    assign rsp_err_o   = fifo_out.err;

`ifdef AXI_LLC_SRAM_SCRUB_EN
    localparam int unsigned ScrubW = cnt_width(ScrubInterval);
    logic [ScrubW-1:0] scrub_cnt_q, scrub_cnt_d;
    logic              scrub_wrap;

    always_comb begin
        scrub_wrap  = (scrub_cnt_q == ScrubW'(ScrubInterval - 1));
        scrub_cnt_d = scrub_wrap ? '0 : scrub_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) scrub_cnt_q <= '0;
        else         scrub_cnt_q <= scrub_cnt_d;
    end

    assign scrub_trigger_o = {NumBanks{scrub_wrap}};
`else
    assign scrub_trigger_o = '0;
`endif
endmodule

// File: tb/tb_axi_llc_sram_ctrl.sv
// Bench for axi_llc_sram_ctrl: directed scenarios plus random traffic against a transaction-level
// model (SRAM contents array, expected-response queue with earliest-visible cycle).
module tb_axi_llc_sram_ctrl;
    localparam int unsigned AW = 10, DW = 64, BW = 8, NB = 2, LAT = 1, DEPTH = 2, SCRUB = 8;

    logic          clk_i = 1'b0, rst_ni = 1'b0;
    logic          req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0, sram_gnt_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0, sram_rdata_i = '0;
    logic [BW-1:0] req_be_i = '0;
    logic [NB-1:0] sram_multi_error_i = '0;
    logic          req_ready_o, rsp_valid_o, rsp_err_o, sram_req_o, sram_we_o;
    logic [DW-1:0] rsp_rdata_o, sram_wdata_o;
    logic [AW-1:0] sram_addr_o;
    logic [BW-1:0] sram_be_o;
    logic [NB-1:0] scrub_trigger_o;

    axi_llc_sram_ctrl #(
        .NumWords(1024), .DataWidth(DW), .ByteWidth(8), .NumBanks(NB),
        .Latency(LAT), .RspDepth(DEPTH), .ScrubInterval(SCRUB)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
        .sram_gnt_i(sram_gnt_i), .sram_rdata_i(sram_rdata_i),
        .sram_multi_error_i(sram_multi_error_i), .scrub_trigger_o(scrub_trigger_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int cyc; logic [DW-1:0] d; logic e; } exp_t;
    typedef struct { int cyc; logic [DW-1:0] d; logic [NB-1:0] e; } sram_t;

    logic [DW-1:0] mem [1024];
    exp_t          exp_q[$];   // accepted reads not yet popped
    sram_t         sq[$];      // SRAM read data scheduled for a future cycle
    int            cyc = 0, sc_k = 0, checks = 0, fails = 0;
    logic          force_en = 1'b0;
    logic [NB-1:0] force_err = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input logic gnt, input logic rdy, output logic acc);
        logic ok, exp_vld, pop;
        logic [NB-1:0] e;
        req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = wd; req_be_i = be;
        sram_gnt_i = gnt; rsp_ready_i = rdy;
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            sram_rdata_i = sq[0].d; sram_multi_error_i = sq[0].e; void'(sq.pop_front());
        end else begin
            sram_rdata_i = {$urandom, $urandom}; sram_multi_error_i = NB'($urandom);
        end
        #1;
        ok = exp_q.size() < DEPTH;
        chk("sram_req", sram_req_o, v & (we | ok));
        chk("req_ready", req_ready_o, gnt & (we | ok));
        if (v) begin
            chk("sram_we", sram_we_o, we);
            chk("sram_addr", sram_addr_o, a);
            if (we) begin
                chk("sram_wdata", sram_wdata_o, wd);
                chk("sram_be", sram_be_o, be);
            end
        end
        exp_vld = exp_q.size() > 0 && exp_q[0].cyc <= cyc;
        chk("rsp_valid", rsp_valid_o, exp_vld);
        if (exp_vld) begin
            chk("rsp_rdata", rsp_rdata_o, exp_q[0].d);
            chk("rsp_err", rsp_err_o, exp_q[0].e);
        end
`ifdef AXI_LLC_SRAM_SCRUB_EN
        chk("scrub", scrub_trigger_o, (sc_k % SCRUB == SCRUB - 1) ? {NB{1'b1}} : '0);
`else
        chk("scrub", scrub_trigger_o, 0);
`endif
        acc = v & gnt & (we | ok);
        pop = exp_vld & rdy;
        if (pop) void'(exp_q.pop_front());
        if (acc && we) begin
            for (int i = 0; i < BW; i++) if (be[i]) mem[a][i*8 +: 8] = wd[i*8 +: 8];
        end else if (acc) begin
            e = force_en ? force_err : (($urandom % 4 == 0) ? NB'($urandom) : '0);
            exp_q.push_back('{cyc + LAT + 1, mem[a], |e});
            sq.push_back('{cyc + LAT, mem[a], e});
        end
        @(posedge clk_i);
        cyc++; sc_k++;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, rdy, acc);
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rdy);
        logic acc;
        int   n = 0;
        do begin
            step(1'b1, we, a, wd, '1, 1'b1, rdy, acc);
            n++;
        end while (!acc && n < 20);
        chk("issue_accepted", acc, 1'b1);
    endtask

    // Entered at a falling edge; releases reset at a falling edge.
    task automatic do_reset();
        rst_ni = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b0; sram_gnt_i = 1'b1; rsp_ready_i = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_scrub", scrub_trigger_o, 0);
        chk("rst_sram_req", sram_req_o, 1);
        chk("rst_req_ready", req_ready_o, 1);
        exp_q.delete(); sq.delete();
        @(posedge clk_i); @(negedge clk_i);
        req_valid_i = 1'b0; rst_ni = 1'b1; sc_k = 0;
    endtask

    initial begin
        logic          acc, pv, pwe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pwd;
        logic [BW-1:0] pbe;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        mem[10'h10] = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk_i);
        do_reset();

        // single read, immediate grant
        issue(1'b0, 10'h10, '0, 1'b1);
        idle(3, 1'b1);

        // grant withheld for three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h20, '0, '1, 1'b0, 1'b1, acc);
        issue(1'b0, 10'h20, '0, 1'b1);
        idle(3, 1'b1);

        // credits exhausted: reads stall, a write still passes, then drain in order
        issue(1'b0, 10'h1, '0, 1'b0);
        issue(1'b0, 10'h2, '0, 1'b0);
        idle(2, 1'b0);
        issue(1'b1, 10'h3, 64'h1234_5678_9ABC_DEF0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h3, '0, '1, 1'b1, 1'b0, acc);
        issue(1'b0, 10'h3, '0, 1'b1);
        issue(1'b0, 10'h4, '0, 1'b1);
        idle(4, 1'b1);

        // uncorrectable error on one bank for one read only
        force_en = 1'b1; force_err = 2'b10;
        issue(1'b0, 10'h5, '0, 1'b1);
        force_err = 2'b00;
        issue(1'b0, 10'h6, '0, 1'b1);
        force_en = 1'b0;
        idle(4, 1'b1);

        // reset with reads outstanding: nothing may surface afterwards
        issue(1'b0, 10'h7, '0, 1'b0);
        issue(1'b0, 10'h8, '0, 1'b0);
        do_reset();
        idle(4, 1'b1);
        issue(1'b0, 10'h9, '0, 1'b1);
        idle(3, 1'b1);

        // random traffic with stable-while-stalled requests
        pv = 1'b0; pwe = 1'b0; pa = '0; pwd = '0; pbe = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pv && ($urandom % 10 < 6)) begin
                pv = 1'b1; pwe = ($urandom % 10 < 3); pa = AW'($urandom % 16);
                pwd = {$urandom, $urandom}; pbe = BW'($urandom);
            end
            step(pv, pwe, pa, pwd, pbe, ($urandom % 4 != 0), ($urandom % 3 != 0), acc);
            if (acc) pv = 1'b0;
        end
        idle(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
